exec_multdiv_unit: RTL and testbench

EXEC_MULTDIV_UNIT -- requirements
Module: exec_multdiv_unit

---
 rtl/exec_multdiv_if.sv | 28 ++
 rtl/exec_multdiv_unit.sv | 184 ++++++++++++++++++
 tb/tb_exec_multdiv_unit.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_multdiv_if.sv
// exec_multdiv_if
//   Connects the D/X stage to the multi-cycle multiply/divide unit.
//   master : pipeline side. Drives in_valid, insn, operand_a, operand_b and pc.
//            Receives stall and the completed-op result bundle.
//   slave  : multdiv unit side.
interface exec_multdiv_if;
  logic        in_valid;
  logic [31:0] insn;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] pc;
  logic        stall;
  logic        out_valid;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic [31:0] out_pc;
  logic        out_exception;

  modport master (
    output in_valid, insn, operand_a, operand_b, pc,
    input  stall, out_valid, out_result, out_rd, out_pc, out_exception
  );

  modport slave (
    input  in_valid, insn, operand_a, operand_b, pc,
    output stall, out_valid, out_result, out_rd, out_pc, out_exception
  );
endinterface

// File: rtl/exec_multdiv_unit.sv
// exec_multdiv_unit
//   Iterative 32-bit signed multiply (radix-2 Booth) and divide (restoring,
//   on magnitudes). Every op takes a fixed 33 cycles from accept to out_valid.
//   clock : rising-edge clock
//   reset : synchronous, active-low
//   bus   : slave side of exec_multdiv_if
//           in_valid/insn/operand_a/operand_b/pc : D/X instruction
//           stall        : combinational freeze request to the front end
//           out_valid    : one-cycle completion pulse
//           out_result   : product low word or quotient
//           out_rd/out_pc: destination register and PC of the completed op
//           out_exception: mul overflow, div by zero or div overflow
module exec_multdiv_unit (
  input logic          clock,
  input logic          reset,
  exec_multdiv_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q;

  // Shared datapath: mul uses hi/lo/qm1 as Booth A:Q:q-1 with m the
  // multiplicand; div uses hi as remainder, lo as dividend/quotient and
  // m as the divisor magnitude.
  logic [32:0] m_q;
  logic [32:0] hi_q;
  logic [31:0] lo_q;
  logic        qm1_q;
  logic        is_div_q;
  logic        neg_q;
  logic        b_zero_q;
  logic [4:0]  rd_q;
  logic [31:0] pc_q;

  logic [31:0] out_result_q;
  logic [4:0]  out_rd_q;
  logic [31:0] out_pc_q;
  logic        out_exception_q;

  logic        dec_mul, dec_div, accept;
  logic        stall_c, out_valid_c;
  logic        unused_insn_bits;

  logic [31:0] a_mag, b_mag;
  logic [32:0] booth_sum;
  logic [32:0] div_sh;
  logic [33:0] div_trial;
  logic [32:0] hi_n;
  logic [31:0] lo_n;
  logic        qm1_n;
  logic [31:0] quot;
  logic [31:0] fin_result;
  logic        fin_exception;

  assign dec_mul = (bus.insn[31:27] == 5'b00000) && (bus.insn[6:2] == 5'b00110);
  assign dec_div = (bus.insn[31:27] == 5'b00000) && (bus.insn[6:2] == 5'b00111);
  assign unused_insn_bits = ^{bus.insn[21:7], bus.insn[1:0]};

  assign accept = reset && bus.in_valid && (dec_mul || dec_div) && (state_q != BUSY);

  assign a_mag = bus.operand_a[31] ? (~bus.operand_a + 32'd1) : bus.operand_a;
  assign b_mag = bus.operand_b[31] ? (~bus.operand_b + 32'd1) : bus.operand_b;

  always_comb begin
    state_d     = state_q;
    stall_c     = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = BUSY;
      end
      BUSY: begin
        stall_c = 1'b1;
        if (count_q == 5'd31) state_d = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        state_d     = accept ? BUSY : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) stall_c = 1'b1;
    if (!reset) stall_c = 1'b0;
  end

  // One iteration of the active algorithm, plus the result that would be
  // committed if this is the final (32nd) iteration.
  always_comb begin
    booth_sum = hi_q;
    div_sh    = {hi_q[31:0], lo_q[31]};
    div_trial = {1'b0, div_sh} - {1'b0, m_q};
    hi_n      = hi_q;
    lo_n      = lo_q;
    qm1_n     = 1'b0;
    if (is_div_q) begin
      if (!div_trial[33]) begin
        hi_n = div_trial[32:0];
        lo_n = {lo_q[30:0], 1'b1};
      end else begin
        hi_n = div_sh;
        lo_n = {lo_q[30:0], 1'b0};
      end
    end else begin
      case ({lo_q[0], qm1_q})
        2'b01:   booth_sum = hi_q + m_q;
        2'b10:   booth_sum = hi_q - m_q;
        default: booth_sum = hi_q;
      endcase
      hi_n  = {booth_sum[32], booth_sum[32:1]};
      lo_n  = {booth_sum[0], lo_q[31:1]};
      qm1_n = lo_q[0];
    end

    quot = neg_q ? (~lo_n + 32'd1) : lo_n;
    if (is_div_q) begin
      fin_result    = b_zero_q ? '0 : quot;
      // A positive quotient with magnitude 2^31 only arises from MIN / -1.
      fin_exception = b_zero_q || (!neg_q && lo_n[31]);
    end else begin
      fin_result    = lo_n;
      fin_exception = (hi_n[31:0] != {32{lo_n[31]}});
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q         <= IDLE;
      count_q         <= '0;
      m_q             <= '0;
      hi_q            <= '0;
      lo_q            <= '0;
      qm1_q           <= 1'b0;
      is_div_q        <= 1'b0;
      neg_q           <= 1'b0;
      b_zero_q        <= 1'b0;
      rd_q            <= '0;
      pc_q            <= '0;
      out_result_q    <= '0;
      out_rd_q        <= '0;
      out_pc_q        <= '0;
      out_exception_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        count_q  <= '0;
        hi_q     <= '0;
        qm1_q    <= 1'b0;
        is_div_q <= dec_div;
        neg_q    <= bus.operand_a[31] ^ bus.operand_b[31];
        b_zero_q <= (bus.operand_b == '0);
        rd_q     <= bus.insn[26:22];
        pc_q     <= bus.pc;
        if (dec_div) begin
          m_q  <= {1'b0, b_mag};
          lo_q <= a_mag;
        end else begin
          m_q  <= {bus.operand_a[31], bus.operand_a};
          lo_q <= bus.operand_b;
        end
      end else if (state_q == BUSY) begin
        count_q <= count_q + 5'd1;
        hi_q    <= hi_n;
        lo_q    <= lo_n;
        qm1_q   <= qm1_n;
        if (count_q == 5'd31) begin
          out_result_q    <= fin_result;
          out_exception_q <= fin_exception;
          out_rd_q        <= rd_q;
          out_pc_q        <= pc_q;
        end
      end
    end
  end

  assign bus.stall         = stall_c;
  assign bus.out_valid     = out_valid_c;
  assign bus.out_result    = out_result_q;
  assign bus.out_rd        = out_rd_q;
  assign bus.out_pc        = out_pc_q;
  assign bus.out_exception = out_exception_q;

endmodule

// File: tb/tb_exec_multdiv_unit.sv
module tb_exec_multdiv_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  exec_multdiv_if bus ();

  exec_multdiv_unit dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    bit          is_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] exp_r;
    bit          exp_e;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        e;
    int          due;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mk_insn(input logic [4:0] alu, input logic [4:0] rd);
    return {5'b00000, rd, 15'b0, alu, 2'b00};
  endfunction

  // Independent reference for the random vectors.
  task automatic model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output bit e);
    logic signed [63:0] p;
    if (!is_div) begin
      p = 64'(signed'(a)) * 64'(signed'(b));
      r = p[31:0];
      e = (p[63:32] != {32{p[31]}});
    end else if (b == 32'd0) begin
      r = '0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      r = signed'(a) / signed'(b);
      e = 1'b0;
    end
  endtask

  // Scoreboard consumer: every out_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("out_result", bus.out_result, x.r);
        chk("out_rd", bus.out_rd, x.rd);
        chk("out_pc", bus.out_pc, x.pc);
        chk("out_exception", bus.out_exception, x.e);
        chk("latency_cycle", cyc, x.due);
      end
    end
  end

  task automatic drive(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] pc);
    bus.in_valid  = 1'b1;
    bus.insn      = mk_insn(is_div ? 5'b00111 : 5'b00110, rd);
    bus.operand_a = a;
    bus.operand_b = b;
    bus.pc        = pc;
  endtask

  // Called #1 after a rising edge; returns #1 after a rising edge.
  task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] pc,
                        input logic [31:0] er, input bit ee);
    int stall_cnt;
    bit seen;
    drive(is_div, a, b, rd, pc);
    @(negedge clk);
    chk("accept_stall", bus.stall, 1);
    sb.push_back('{er, rd, pc, ee, cyc + 33});
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    stall_cnt = 0;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1;
        chk("done_stall", bus.stall, 0);
      end else if (bus.stall) begin
        stall_cnt++;
      end
      @(posedge clk);
      #1;
      // Live-looking traffic while busy must be ignored.
      if (k < 20) begin
        bus.in_valid  = 1'b1;
        bus.insn      = mk_insn(5'b00110, 5'(k));
        bus.operand_a = $urandom;
        bus.operand_b = $urandom;
        bus.pc        = $urandom;
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    chk("out_valid_seen", seen, 1);
    chk("busy_stall_cycles", stall_cnt, 32);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb, rr;
    bit          re, rdiv;
    int          nv;

    vecs[0]  = '{0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'h10, 32'hFFFF_FFEB, 0};
    vecs[1]  = '{0, 32'h0001_0000,  32'h0001_0000, 5'd1,  32'h14, 32'h0000_0000, 1};
    vecs[2]  = '{1, 32'hFFFF_FFF9,  32'd2,         5'd2,  32'h18, 32'hFFFF_FFFD, 0};
    vecs[3]  = '{1, 32'd9,          32'd0,         5'd3,  32'h1C, 32'h0000_0000, 1};
    vecs[4]  = '{1, 32'h8000_0000,  32'hFFFF_FFFF, 5'd4,  32'h20, 32'h8000_0000, 1};
    vecs[5]  = '{0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  32'h24, 32'h0000_0001, 0};
    vecs[6]  = '{0, 32'h8000_0000,  32'hFFFF_FFFF, 5'd7,  32'h28, 32'h8000_0000, 1};
    vecs[7]  = '{1, 32'hFFFF_FF9C,  32'd7,         5'd8,  32'h2C, 32'hFFFF_FFF2, 0};
    vecs[8]  = '{1, 32'd7,          32'hFFFF_FF9C, 5'd9,  32'h30, 32'h0000_0000, 0};
    vecs[9]  = '{0, 32'h7FFF_FFFF,  32'd2,         5'd10, 32'h34, 32'hFFFF_FFFE, 1};
    vecs[10] = '{0, 32'h8000_0000,  32'h8000_0000, 5'd11, 32'h38, 32'h0000_0000, 1};
    vecs[11] = '{1, 32'h8000_0000,  32'd2,         5'd12, 32'h3C, 32'hC000_0000, 0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.insn      = '0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.pc        = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", bus.stall, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_result", bus.out_result, 0);
    chk("rst_out_rd", bus.out_rd, 0);
    chk("rst_out_pc", bus.out_pc, 0);
    chk("rst_out_exception", bus.out_exception, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i])
      run_op(vecs[i].is_div, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].pc,
             vecs[i].exp_r, vecs[i].exp_e);

    for (int i = 0; i < 6; i++) begin
      rdiv = i[0];
      ra   = $urandom;
      rb   = (i < 2) ? $urandom : 32'($urandom_range(1, 5000)) * ((i % 3 == 0) ? 32'hFFFF_FFFF : 32'd1);
      model(rdiv, ra, rb, rr, re);
      run_op(rdiv, ra, rb, 5'(20 + i), 32'h100 + 32'(i), rr, re);
    end

    // Back-to-back: a new op presented in the DONE cycle is taken immediately.
    drive(1, 32'd100, 32'd7, 5'd13, 32'h40);
    @(negedge clk);
    sb.push_back('{32'd14, 5'd13, 32'h40, 1'b0, cyc + 33});
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (32) @(posedge clk);
    #1 drive(0, 32'd6, 32'd7, 5'd14, 32'h44);
    @(negedge clk);
    chk("b2b_out_valid", bus.out_valid, 1);
    chk("b2b_stall", bus.stall, 1);
    sb.push_back('{32'd42, 5'd14, 32'h44, 1'b0, cyc + 33});
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    nv = 0;
    while (sb.size() != 0 && nv < 40) begin
      @(posedge clk);
      nv++;
    end
    chk("b2b_drained", sb.size(), 0);
    @(posedge clk);
    #1;

    // Non-mul/div instruction: ignored entirely.
    bus.in_valid = 1'b1;
    bus.insn     = mk_insn(5'b00000, 5'd3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("add_no_stall", bus.stall, 0);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    nv = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.out_valid) nv++;
    end
    chk("add_no_out_valid", nv, 0);
    @(posedge clk);
    #1;

    // Reset in the middle of a multiply.
    drive(0, 32'h1234, 32'd3, 5'd9, 32'h200);
    @(negedge clk);
    sb.push_back('{32'h369C, 5'd9, 32'h200, 1'b0, cyc + 33});
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_stall", bus.stall, 0);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_out_result", bus.out_result, 0);
    chk("mid_rst_out_rd", bus.out_rd, 0);
    chk("mid_rst_out_pc", bus.out_pc, 0);
    chk("mid_rst_out_exception", bus.out_exception, 0);
    nv = 0;
    for (int k = 0; k < 29; k++) begin
      @(negedge clk);
      if (bus.out_valid) nv++;
    end
    chk("mid_rst_no_out_valid", nv, 0);
    @(posedge clk);
    #1;

    // Unit must be usable again after the abort.
    run_op(0, 32'd6, 32'hFFFF_FFF9, 5'd15, 32'h300, 32'hFFFF_FFD6, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
